fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the RV32I core. It sits directly upstream of decode and immediate generation. It owns the program counter, issues word requests to instruction memory over a valid/ready request and valid response interface, and buffers returned instructions with their PC in a small FIFO. Decode pops `inst_code`/`inst_pc` with a valid/ready handshake. Branch resolution (PC + immediate) redirects fetch through `redirect_valid`/`redirect_pc`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries. Must be ≥1 and a power of two.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `imem_req_valid`, output, 1: fetch request.
- `imem_req_ready`, input, 1: memory accepts the request.
- `imem_addr`, output, 32: word address of the request. Bits [1:0] are always 0.
- `imem_rsp_valid`, input, 1: response data valid. Exactly one response per accepted request.
- `imem_rsp_data`, input, 32: instruction word.
- `inst_valid`, output, 1: FIFO head valid toward decode.
- `inst_ready`, input, 1: decode consumes the head.
- `inst_code`, output, 32: head instruction.
- `inst_pc`, output, 32: PC of the head instruction.
- `redirect_valid`, input, 1: single-cycle pulse to redirect fetch.
- `redirect_pc`, input, 32: redirect target.
- `misalign_err`, output, 1: one-cycle pulse when a redirect target has [1:0] ≠ 0.

## Operation
- FSM states are `S_REQ` and `S_WAIT`. At most one memory request is outstanding.
- **`S_REQ` request condition:** `imem_req_valid = (occupancy < FIFO_DEPTH) && !redirect_valid`.
- **`S_REQ` address:** `imem_addr = pc`.
- **`S_REQ` on handshake** (`imem_req_valid && imem_req_ready`):
  - `pc_inflight <= pc`
  - `pc <= pc + 4` (mod 2^32; wraps 32'hFFFF_FFFC → 0)
  - go to `S_WAIT`.
- **Request retraction:** `imem_req_valid` may drop without a handshake, on a redirect or a full FIFO. The memory must not rely on request stability.
- **`S_WAIT` on `imem_rsp_valid`:**
  - If `stale` = 0, push {`pc_inflight`, `imem_rsp_data`}.
  - If `stale` = 1, discard the data.
  - Clear `stale` and go to `S_REQ`.
- **Redirect, any state:**
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - FIFO is flushed (occupancy → 0).
  - `misalign_err` pulses if `redirect_pc[1:0]` ≠ 0.
- **Redirect in `S_WAIT`:** sets `stale`. If `imem_rsp_valid` arrives in the same cycle, that response is discarded and the FSM goes to `S_REQ` with `stale` = 0.
- **Redirect in `S_REQ`:** no request is issued that cycle.
- **Flush versus pop:** a redirect has priority over a pop in the same cycle. The flush wins and a pop in that cycle has no extra effect.
- **FIFO push and pop in the same cycle:** both occur and occupancy is unchanged. A push to an empty FIFO is not visible on `inst_valid` until the next cycle (no bypass).
- **Output stability:** while `inst_valid && !inst_ready`, `inst_code` and `inst_pc` hold stable.
- **Space check:** the occupancy check in `S_REQ` guarantees buffer space for the outstanding response. The FIFO never overflows, and responses are never back-pressured.

## Timing
- **Reset values (asynchronous, immediate):**
  - `pc = RESET_PC`, state `S_REQ`, `stale` = 0, occupancy 0.
  - `imem_req_valid` = 0 while `rst_n` = 0.
  - `imem_addr = RESET_PC`.
  - `inst_valid` = 0, `inst_code` = 0, `inst_pc` = 0.
  - `misalign_err` = 0.
- **After reset:** `imem_req_valid` rises in the first cycle after `rst_n` deasserts.
- **Memory response latency:** ≥1 cycle after acceptance.
- **Fetch latency:** request accepted in cycle N, response in N+1 → `inst_valid` in N+2.
- **Throughput:** at most one instruction every 2 cycles (REQ + WAIT).
- **Redirect to request:** redirect in cycle N → `imem_addr = redirect target` with `imem_req_valid` possible in N+1. If the FSM is in `S_WAIT`, the request waits for the stale response.
- **Reset asserted mid-operation:** all state is cleared immediately. A memory response arriving after reset release without a matching accepted request is ignored, because the FSM is in `S_REQ`.

## Structure
- Package `fetch_pkg` holds:
  - `fetch_state_t` enum (`S_REQ`, `S_WAIT`).
  - `fetch_entry_t` struct {pc[31:0], inst[31:0]}.
  - `INST_NOP` = 32'h0000_0013.
  - Default `RESET_PC`.
- Sub-module `inst_fifo`: parameterized depth, synchronous `flush`, push/pop, `count`, registered storage of `fetch_entry_t`, asynchronous active-low reset.
- `fetch_stage` contains the PC register, FSM, `stale` flag and the `inst_fifo` instance.

## Test plan
- **Reset and streaming:** memory `ready` = 1, 1-cycle response, decode `ready` = 1 → addresses 0x0, 0x4, 0x8 issued every 2 cycles; `inst_pc` 0x0/0x4/0x8 carry matching data; first `inst_valid` two cycles after the first handshake.
- **Backpressure:** `inst_ready` = 0 → two entries fill, `imem_req_valid` drops and stays 0; raising `inst_ready` drains 0x0 then 0x4 in order, and fetching resumes at 0x8.
- **Redirect during `S_WAIT`:** request 0x10 outstanding, redirect to 0x200 → response for 0x10 never appears on `inst_*`; next `imem_addr` = 0x200; FIFO flushed.
- **Redirect coincident with response and pop:** all three in the same cycle → the data is dropped, occupancy = 0, next request is to the target.
- **Misaligned redirect:** `redirect_pc` = 0x103 → `misalign_err` is a 1-cycle pulse and the next `imem_addr` = 0x100.
- **Wrap and reset mid-run:** `RESET_PC` = 0xFFFF_FFFC → the second request is to 0x0; asserting `rst_n` = 0 with a full FIFO → `inst_valid` and `imem_req_valid` fall immediately, and `pc` returns to `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Small circular buffer of {pc, inst} entries between fetch and decode.
// Flush wins over push/pop; there is no bypass from push to head.
module inst_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fetch_entry_t                 push_entry_i,
    input  logic                         pop_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding request FSM, stale-response
// tracking across redirects, and the instruction buffer toward decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [31:0]  imem_addr,
    input  logic         imem_rsp_valid,
    input  logic [31:0]  imem_rsp_data,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [31:0]  inst_code,
    output logic [31:0]  inst_pc,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         misalign_err,
    output fetch_state_t dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready. imem_req_valid may be withdrawn without a
    // transfer (redirect or full buffer). Responses have no ready: the space
    // check before issuing guarantees room for the one outstanding word.

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_inflight_q, pc_inflight_d;
    logic             stale_q, stale_d;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head;
    fetch_entry_t     rsp_entry;
    logic             rsp_push, inst_pop, has_space, req_fire;

    assign has_space      = fifo_count < CNT_W'(FIFO_DEPTH);
    assign imem_req_valid = rst_n && (state_q == S_REQ) && has_space && !redirect_valid;
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid = (fifo_count != '0);
    assign inst_pop   = inst_valid && inst_ready;
    assign inst_code  = inst_valid ? fifo_head.inst : '0;
    assign inst_pc    = inst_valid ? fifo_head.pc   : '0;

    assign misalign_err = rst_n && redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign dbg_state    = state_q;
    assign rsp_entry    = '{pc: pc_inflight_q, inst: imem_rsp_data};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_inflight_d = pc_inflight_q;
        stale_d       = stale_q;
        rsp_push      = 1'b0;
        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    pc_inflight_d = pc_q;
                    pc_d          = pc_q + 32'd4;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                // A redirect in the response cycle kills the word directly.
                if (imem_rsp_valid) begin
                    rsp_push = !stale_q && !redirect_valid;
                    stale_d  = 1'b0;
                    state_d  = S_REQ;
                end else if (redirect_valid) begin
                    stale_d = 1'b1;
                end
            end
            default: state_d = S_REQ;
        endcase
        if (redirect_valid) pc_d = word_align(redirect_pc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            pc_inflight_q <= RESET_PC;
            stale_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_inflight_q <= pc_inflight_d;
            stale_q       <= stale_d;
        end
    end

    inst_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (redirect_valid),
        .push_i       (rsp_push),
        .push_entry_i (rsp_entry),
        .pop_i        (inst_pop),
        .head_o       (fifo_head),
        .count_o      (fifo_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, backpressure, redirects, wrap and reset.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         imem_req_valid, imem_req_ready;
    logic [31:0]  imem_addr;
    logic         imem_rsp_valid;
    logic [31:0]  imem_rsp_data;
    logic         inst_valid, inst_ready;
    logic [31:0]  inst_code, inst_pc;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         misalign_err;
    fetch_state_t dbg_state;

    // Second instance: reset PC at the top of the address space, memory always ready, never responds.
    logic         w_req_valid, w_req_ready;
    logic [31:0]  w_addr;
    logic         w_rsp_valid;
    logic [31:0]  w_rsp_data;
    logic         w_inst_valid, w_inst_ready;
    logic [31:0]  w_inst_code, w_inst_pc;
    logic         w_redirect_valid;
    logic [31:0]  w_redirect_pc;
    logic         w_misalign_err;
    fetch_state_t w_dbg_state;

    int          n_cmp;
    int          n_err;
    logic [63:0] exp_q[$];

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_code      (inst_code),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err),
        .dbg_state      (dbg_state)
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (w_req_ready),
        .imem_addr      (w_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .inst_valid     (w_inst_valid),
        .inst_ready     (w_inst_ready),
        .inst_code      (w_inst_code),
        .inst_pc        (w_inst_pc),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .misalign_err   (w_misalign_err),
        .dbg_state      (w_dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, required finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks: inputs change and outputs are sampled 2-3 units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare the head toward decode with the oldest expected entry.
    task automatic chk_head(input string tag, input bit pop_it);
        logic [63:0] e;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s_scoreboard: observed empty expected queue, expected an entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = pop_it ? exp_q.pop_front() : exp_q[0];
            chk1({tag, "_valid"}, inst_valid, 1'b1);
            chk32({tag, "_pc"}, inst_pc, e[63:32]);
            chk32({tag, "_code"}, inst_code, e[31:0]);
        end
    endtask

    // One request/response pair with a 1-cycle memory; ends in the cycle the word is visible.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
        chk1("req_valid", imem_req_valid, 1'b1);
        chk32("req_addr", imem_addr, addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #1;
        chk1("req_low_in_wait", imem_req_valid, 1'b0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        #1;
        exp_q.push_back({addr, data});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        w_req_ready      = 1'b1;
        w_rsp_valid      = 1'b0;
        w_rsp_data       = '0;
        w_inst_ready     = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;

        // Reset values
        tick();
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk32("rst_addr", imem_addr, 32'h0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk32("rst_inst_code", inst_code, 32'h0);
        chk32("rst_inst_pc", inst_pc, 32'h0);
        chk1("rst_misalign", misalign_err, 1'b0);
        chk1("wrap_rst_req_valid", w_req_valid, 1'b0);
        chk32("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);

        rst_n = 1'b1;
        #1;
        chk1("req_after_reset", imem_req_valid, 1'b1);

        // Streaming with decode always ready
        inst_ready = 1'b1;
        do_fetch(32'h0000_0000, 32'h0010_0093);
        chk_head("stream0", 1'b1);
        chk32("wrap_second_addr", w_addr, 32'h0000_0000);
        chk1("wrap_waits", w_req_valid, 1'b0);
        do_fetch(32'h0000_0004, 32'h0020_0113);
        chk_head("stream1", 1'b1);
        do_fetch(32'h0000_0008, 32'h0030_0193);
        chk_head("stream2", 1'b1);
        tick();
        #1;
        chk1("stream_drained", inst_valid, 1'b0);

        // Backpressure: fill both entries, requests stop, then drain in order
        inst_ready = 1'b0;
        do_fetch(32'h0000_000C, 32'h0040_0213);
        chk_head("bp_first", 1'b0);
        do_fetch(32'h0000_0010, 32'h0050_0293);
        chk1("bp_req_dropped", imem_req_valid, 1'b0);
        chk_head("bp_hold0", 1'b0);
        tick();
        #1;
        chk1("bp_req_still_low", imem_req_valid, 1'b0);
        chk_head("bp_hold1", 1'b0);
        inst_ready = 1'b1;
        chk_head("bp_drain0", 1'b1);
        tick();
        #1;
        chk_head("bp_drain1", 1'b1);
        chk1("bp_req_resumes", imem_req_valid, 1'b1);
        chk32("bp_resume_addr", imem_addr, 32'h0000_0014);
        tick();
        #1;
        chk1("bp_empty", inst_valid, 1'b0);
        inst_ready = 1'b0;
        do_fetch(32'h0000_0014, 32'h0060_0313);
        chk_head("pre_redirect", 1'b0);

        // Redirect while a request is outstanding
        chk32("rw_req_addr", imem_addr, 32'h0000_0018);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        chk1("rw_misalign_low", misalign_err, 1'b0);
        chk1("rw_no_req", imem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        exp_q.delete();
        #1;
        chk1("rw_flushed", inst_valid, 1'b0);
        chk1("rw_wait_stale", imem_req_valid, 1'b0);
        chk32("rw_target_addr", imem_addr, 32'h0000_0200);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_0013;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        chk1("rw_stale_dropped", inst_valid, 1'b0);
        do_fetch(32'h0000_0200, 32'h0070_0393);
        chk_head("rw_target", 1'b0);

        // Redirect, response and pop all in one cycle
        chk32("co_req_addr", imem_addr, 32'h0000_0204);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0080_0413;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        inst_ready     = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        #1;
        chk1("co_empty", inst_valid, 1'b0);
        chk1("co_req_valid", imem_req_valid, 1'b1);
        chk32("co_target_addr", imem_addr, 32'h0000_0300);
        tick();
        #1;
        chk1("co_still_empty", inst_valid, 1'b0);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        chk1("mis_pulse", misalign_err, 1'b1);
        chk1("mis_no_req", imem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk1("mis_pulse_end", misalign_err, 1'b0);
        chk32("mis_aligned_addr", imem_addr, 32'h0000_0100);
        chk1("mis_req_valid", imem_req_valid, 1'b1);

        // Reset asserted with a full buffer
        do_fetch(32'h0000_0100, 32'h0090_0493);
        do_fetch(32'h0000_0104, 32'h00A0_0513);
        chk1("full_req_low", imem_req_valid, 1'b0);
        chk_head("full_head", 1'b0);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk1("midrst_inst_valid", inst_valid, 1'b0);
        chk1("midrst_req_valid", imem_req_valid, 1'b0);
        chk32("midrst_addr", imem_addr, 32'h0000_0000);
        chk32("midrst_inst_pc", inst_pc, 32'h0000_0000);
        chk32("midrst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        tick();
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0013;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        chk1("orphan_rsp_ignored", inst_valid, 1'b0);
        chk1("post_rst_req_valid", imem_req_valid, 1'b1);
        chk32("post_rst_addr", imem_addr, 32'h0000_0000);
        chk32("post_rst_wrap_addr", w_addr, 32'h0000_0000);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
